// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the decode stage (master) and muldiv_unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, opcode, left, right,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, opcode, left, right,
        output ready, busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide, one result bit per cycle (shift-add / restoring divide).
// Define MULDIV_EARLY_OUT_EN to skip iteration for divide-by-zero, signed overflow and zero multiply operands.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   left_q, left_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic               mzero_q, mzero_d;

    // Decode of the operands presented with start.
    logic             is_div, l_sgn, r_sgn, l_neg, r_neg;
    logic [WIDTH-1:0] abs_l, abs_r;
    logic             in_div0, in_ovf, in_mzero, accept;

    always_comb begin
        is_div   = bus.opcode[2];
        l_sgn    = (bus.opcode == OP_MULH) | (bus.opcode == OP_MULHSU) |
                   (bus.opcode == OP_DIV)  | (bus.opcode == OP_REM);
        r_sgn    = (bus.opcode == OP_MULH) | (bus.opcode == OP_DIV) | (bus.opcode == OP_REM);
        l_neg    = l_sgn & bus.left[WIDTH-1];
        r_neg    = r_sgn & bus.right[WIDTH-1];
        abs_l    = l_neg ? -bus.left  : bus.left;
        abs_r    = r_neg ? -bus.right : bus.right;
        in_div0  = is_div & (bus.right == '0);
        in_ovf   = is_div & l_sgn & (bus.left == MOST_NEG) & (bus.right == '1);
        in_mzero = !is_div & ((bus.left == '0) | (bus.right == '0));
    end

    // Iteration datapath. acc holds {partial product, multiplier} for mul
    // and {partial remainder, dividend/quotient} for div.
    logic [WIDTH:0] mul_sum, div_trial, div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, mcand_q};
    end

    // Final sign correction and half selection.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_base, fin_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_base = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        fin_res  = '0;
        if (op_q[2]) begin
            if (div0_q)
                fin_res = op_q[1] ? left_q : '1;
            else if (ovf_q)
                fin_res = op_q[1] ? '0 : MOST_NEG;
            else
                fin_res = neg_q ? -div_base : div_base;
        end else if (!mzero_q) begin
            fin_res = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        left_d   = left_q;
        result_d = result_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        mzero_d  = mzero_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                accept  = bus.start;
                state_d = S_IDLE;
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2])
                    acc_d = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                            : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIN;
            end
            S_FIN: begin
                result_d = fin_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d    = bus.opcode;
            left_d  = bus.left;
            mcand_d = is_div ? abs_r : abs_l;
            acc_d   = {{WIDTH{1'b0}}, (is_div ? abs_l : abs_r)};
            // Remainder follows the dividend; everything else follows the operand signs.
            neg_d   = (is_div & bus.opcode[1]) ? l_neg : (l_neg ^ r_neg);
            div0_d  = in_div0;
            ovf_d   = in_ovf;
            mzero_d = in_mzero;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
            if (in_div0 | in_ovf | in_mzero)
                state_d = S_FIN;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            left_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            left_q   <= left_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            mzero_q  <= mzero_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE) | (state_q == S_DONE);
    assign bus.busy   = (state_q == S_CALC) | (state_q == S_FIN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Random + directed check of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int LAT = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        bit ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; if (ovf) return MIN; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; if (ovf) return '0; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit early_case(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op >= 3'd4)
            return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MIN;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op at a negedge; inj>0 pulses a stray start at that busy cycle.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        logic [W-1:0] exp_r;
        int lat, exp_lat;
        logic hs_bad;
        exp_r   = ref_fn(op, a, b);
        exp_lat = (EO && early_case(op, a, b)) ? 2 : LAT;
        bus.start = 1'b1; bus.opcode = op; bus.left = a; bus.right = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.opcode = 3'($urandom); bus.left = 32'($urandom); bus.right = 32'($urandom);
        lat = 1;
        hs_bad = 1'b0;
        while (!bus.done && lat < 200) begin
            if (!bus.busy || bus.ready) hs_bad = 1'b1;
            bus.start = (lat == inj);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk($sformatf("lat op%0d", op), 64'(lat), 64'(exp_lat));
        chk($sformatf("res op%0d %h %h", op, a, b), 64'(bus.result), 64'(exp_r));
        chk("busy/ready", 64'(hs_bad), 64'd0);
    endtask

    logic [2:0]   d_op [15] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0};
    logic [W-1:0] d_a  [15] = '{32'd7, '1, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                32'd5, 32'd5, MIN, MIN, 32'd9, 32'd9, 32'd0};
    logic [W-1:0] d_b  [15] = '{32'd3, '1, '1, '1, 32'd2, 32'd2, 32'd3, 32'd3,
                                32'd0, 32'd0, '1, '1, 32'd0, 32'd0, 32'd1234};

    initial begin
        bit seen;
        bus.start = 1'b0; bus.opcode = '0; bus.left = '0; bus.right = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 64'(bus.ready), 64'd1);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;

        // Directed cases, issued back-to-back from the DONE cycle.
        for (int i = 0; i < 15; i++) issue(d_op[i], d_a[i], d_b[i], 0);

        // Stray start mid-CALC with other operands must be ignored.
        issue(3'd0, 32'd7, 32'd3, 10);

        for (int i = 0; i < 150; i++) issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 0);

        // Reset around CALC cycle 10 aborts silently.
        bus.start = 1'b1; bus.opcode = 3'd0; bus.left = 32'd9; bus.right = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst ready", 64'(bus.ready), 64'd1);
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst result", 64'(bus.result), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("midrst no done", 64'(seen), 64'd0);
        issue(3'd0, 32'd4, 32'd3, 0);
        chk("post-rst mul", 64'(bus.result), 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
